// File: rtl/button_conditioner.sv
// N-channel push-button conditioner: 2-flop synchroniser, tick-sampled debounce,
// press/release pulses and an optional hold-to-repeat fire stream per channel.
module button_conditioner #(
  parameter int unsigned N_CH          = 2,
  parameter int unsigned TICK_DIV      = 25000,
  parameter int unsigned STABLE_TICKS  = 4,
  parameter int unsigned REPEAT_DELAY  = 20,
  parameter int unsigned REPEAT_PERIOD = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_i,
  input  logic [N_CH-1:0] repeat_en_i,
  output logic [N_CH-1:0] level_o,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] release_o,
  output logic [N_CH-1:0] fire_o,
  output logic            tick_o
);

  localparam int unsigned PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned CW   = $clog2(STABLE_TICKS + 1);
  localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RW   = $clog2(RMAX + 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } rep_state_e;

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;
  logic [PW-1:0]   pcnt_q, pcnt_d;
  logic            tick_q, tick_d;

  // Free-running prescaler; tick_q is high exactly while pcnt_q == TICK_DIV-1
  always_comb begin
    pcnt_d = pcnt_q + PW'(1);
    if (pcnt_q == PW'(TICK_DIV - 1)) begin
      pcnt_d = '0;
    end
    tick_d = (pcnt_d == PW'(TICK_DIV - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      pcnt_q  <= '0;
      tick_q  <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      pcnt_q  <= pcnt_d;
      tick_q  <= tick_d;
    end
  end

  assign tick_o = tick_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    logic          level_q,   level_d;
    logic          press_q,   press_d;
    logic          release_q, release_d;
    logic          fire_q,    fire_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [RW-1:0] rcnt_q,    rcnt_d;
    rep_state_e    state_q,   state_d;
    logic          rep_c;
    logic [CW-1:0] cnt_inc_c;
    logic [RW-1:0] rcnt_inc_c;

    always_comb begin
      level_d    = level_q;
      cnt_d      = cnt_q;
      state_d    = state_q;
      rcnt_d     = rcnt_q;
      rep_c      = 1'b0;
      cnt_inc_c  = cnt_q + CW'(1);
      rcnt_inc_c = rcnt_q + RW'(1);

      // Debounce: level flips only after STABLE_TICKS consecutive mismatching ticks
      if (tick_q) begin
        if (sync2_q[i] != level_q) begin
          if (cnt_inc_c == CW'(STABLE_TICKS)) begin
            level_d = ~level_q;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_inc_c;
          end
        end else begin
          cnt_d = '0;
        end
      end

      press_d   = level_d & ~level_q;
      release_d = ~level_d & level_q;

      // Repeat FSM; release or disable silently returns to idle from any state
      if (!repeat_en_i[i] || release_d) begin
        state_d = ST_IDLE;
        rcnt_d  = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (press_d) begin
              state_d = ST_DELAY;
              rcnt_d  = '0;
            end
          end
          ST_DELAY: begin
            if (tick_q) begin
              if (rcnt_inc_c == RW'(REPEAT_DELAY)) begin
                rep_c   = 1'b1;
                state_d = ST_REPEAT;
                rcnt_d  = '0;
              end else begin
                rcnt_d = rcnt_inc_c;
              end
            end
          end
          ST_REPEAT: begin
            if (tick_q) begin
              if (rcnt_inc_c == RW'(REPEAT_PERIOD)) begin
                rep_c  = 1'b1;
                rcnt_d = '0;
              end else begin
                rcnt_d = rcnt_inc_c;
              end
            end
          end
          default: begin
            state_d = ST_IDLE;
            rcnt_d  = '0;
          end
        endcase
      end

      fire_d = press_d | rep_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
        fire_q    <= 1'b0;
        cnt_q     <= '0;
        rcnt_q    <= '0;
        state_q   <= ST_IDLE;
      end else begin
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
        fire_q    <= fire_d;
        cnt_q     <= cnt_d;
        rcnt_q    <= rcnt_d;
        state_q   <= state_d;
      end
    end

    assign level_o[i]   = level_q;
    assign press_o[i]   = press_q;
    assign release_o[i] = release_q;
    assign fire_o[i]    = fire_q;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: expected pulse events with cycle windows
// are queued as stimulus is driven and matched as the DUT emits them.
module tb_button_conditioner;

  localparam int N_CH          = 2;
  localparam int TICK_DIV      = 4;
  localparam int STABLE_TICKS  = 3;
  localparam int REPEAT_DELAY  = 5;
  localparam int REPEAT_PERIOD = 2;
  localparam int DLY     = REPEAT_DELAY * TICK_DIV;
  localparam int PER     = REPEAT_PERIOD * TICK_DIV;
  localparam int LAT_MIN = 2 + (STABLE_TICKS - 1) * TICK_DIV + 1;
  localparam int LAT_MAX = 2 + STABLE_TICKS * TICK_DIV;
  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_FIRE  = 2;

  typedef struct {
    int ch;
    int kind;
    int lo;
    int hi;
  } exp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] ren;
  logic [N_CH-1:0] level_o, press_o, release_o, fire_o;
  logic            tick_o;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   last_tick = -1;
  int   press_cnt [N_CH];
  int   press_t   [N_CH];
  exp_t exp_q[$];

  button_conditioner #(
    .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_TICKS(STABLE_TICKS),
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_PERIOD(REPEAT_PERIOD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .btn_i(btn), .repeat_en_i(ren),
    .level_o(level_o), .press_o(press_o), .release_o(release_o),
    .fire_o(fire_o), .tick_o(tick_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic string kname(input int kind);
    return (kind == K_PRESS) ? "press" : (kind == K_REL) ? "release" : "fire";
  endfunction

  function automatic int outs();
    return int'({level_o, press_o, release_o, fire_o, tick_o});
  endfunction

  task automatic expect_ev(input int ch, input int kind, input int lo, input int hi);
    exp_t e;
    e.ch = ch; e.kind = kind; e.lo = lo; e.hi = hi;
    exp_q.push_back(e);
  endtask

  // Pop the oldest expectation for this channel/kind and check its timing
  task automatic match_event(input int ch, input int kind, input int t);
    int idx;
    idx = -1;
    foreach (exp_q[i]) begin
      if (idx < 0 && exp_q[i].ch == ch && exp_q[i].kind == kind) idx = i;
    end
    if (idx < 0) begin
      check($sformatf("unexpected_%s%0d_at_%0d", kname(kind), ch, t), 1, 0);
    end else begin
      if (exp_q[idx].lo == exp_q[idx].hi)
        check($sformatf("%s%0d_time", kname(kind), ch), t, exp_q[idx].lo);
      else
        check($sformatf("%s%0d_at_%0d_window_%0d_%0d", kname(kind), ch, t,
                        exp_q[idx].lo, exp_q[idx].hi),
              int'(t >= exp_q[idx].lo && t <= exp_q[idx].hi), 1);
      exp_q.delete(idx);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_tick <= -1;
    end else begin
      if (tick_o) begin
        if (last_tick >= 0) check("tick_period", cyc - last_tick, TICK_DIV);
        last_tick <= cyc;
      end
      if ((press_o & release_o) != '0)
        check("press_release_overlap", int'(press_o & release_o), 0);
      for (int ch = 0; ch < N_CH; ch++) begin
        if (press_o[ch]) begin
          match_event(ch, K_PRESS, cyc);
          press_cnt[ch] <= press_cnt[ch] + 1;
          press_t[ch]   <= cyc;
        end
        if (release_o[ch]) match_event(ch, K_REL, cyc);
        if (fire_o[ch])    match_event(ch, K_FIRE, cyc);
      end
    end
  end

  task automatic wait_until(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  task automatic wait_press(input int ch, input string tag, output int t);
    int  c0;
    bit  ok;
    c0 = press_cnt[ch];
    ok = 1'b0;
    for (int i = 0; i < 3 * LAT_MAX && !ok; i++) begin
      @(negedge clk);
      if (press_cnt[ch] != c0) ok = 1'b1;
    end
    if (!ok) begin
      check({tag, "_press_timeout"}, 0, 1);
      t = cyc;
    end else begin
      t = press_t[ch];
    end
  endtask

  task automatic press_windows(input int ch, input int t0);
    expect_ev(ch, K_PRESS, t0 + LAT_MIN, t0 + LAT_MAX);
    expect_ev(ch, K_FIRE,  t0 + LAT_MIN, t0 + LAT_MAX);
  endtask

  task automatic release_btn(input int ch);
    btn[ch] = 1'b0;
    expect_ev(ch, K_REL, cyc + LAT_MIN, cyc + LAT_MAX);
  endtask

  task automatic drain(input string tag);
    wait_until(cyc + LAT_MAX + 8);
    check({tag, "_pending"}, exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int rel, p, s;
    foreach (press_cnt[i]) begin press_cnt[i] = 0; press_t[i] = 0; end
    rst_n = 1'b0;
    btn   = 2'b11;
    ren   = 2'b00;

    // 1: reset with buttons held, then debounce latency after release
    repeat (5) @(negedge clk);
    check("reset_outputs", outs(), 0);
    rst_n = 1'b1;
    rel   = cyc;
    press_windows(0, rel);
    press_windows(1, rel);
    @(negedge clk);
    check("first_cycle_outputs", outs(), 0);
    wait_until(rel + LAT_MIN - 1);
    check("p1_level_early", int'(level_o), 0);
    wait_until(rel + LAT_MAX);
    check("p1_level_set", int'(level_o), 3);
    wait_until(cyc + 6);
    release_btn(0);
    release_btn(1);
    drain("p1");
    check("p1_level_clear", int'(level_o), 0);

    // 2: short glitch must be rejected
    btn[0] = 1'b1;
    repeat (6) @(negedge clk);
    btn[0] = 1'b0;
    wait_until(cyc + 30);
    check("p2_level", int'(level_o), 0);
    check("p2_pending", exp_q.size(), 0);

    // 3: long press on channel 1 without repeat
    btn[1] = 1'b1;
    press_windows(1, cyc);
    s = cyc;
    wait_until(s + 100);
    check("p3_level_held", int'(level_o), 2);
    wait_until(s + 200);
    release_btn(1);
    drain("p3");

    // 4: auto-repeat on channel 0
    ren    = 2'b01;
    btn[0] = 1'b1;
    press_windows(0, cyc);
    wait_press(0, "p4", p);
    for (int k = 0; DLY + k * PER <= 108; k++) expect_ev(0, K_FIRE, p + DLY + k * PER, p + DLY + k * PER);
    check("p4_level_held", int'(level_o[0]), 1);
    wait_until(p + 100);
    release_btn(0);
    drain("p4");

    // 5: disable mid-repeat, re-enable while held, then re-press
    btn[0] = 1'b1;
    press_windows(0, cyc);
    wait_press(0, "p5a", p);
    expect_ev(0, K_FIRE, p + DLY, p + DLY);
    expect_ev(0, K_FIRE, p + DLY + PER, p + DLY + PER);
    wait_until(p + 30);
    ren = 2'b00;
    wait_until(p + 50);
    ren = 2'b01;
    wait_until(p + 90);
    check("p5_level_held", int'(level_o[0]), 1);
    release_btn(0);
    drain("p5a");
    btn[0] = 1'b1;
    press_windows(0, cyc);
    wait_press(0, "p5b", p);
    for (int k = 0; k < 3; k++) expect_ev(0, K_FIRE, p + DLY + k * PER, p + DLY + k * PER);
    wait_until(p + 30);
    release_btn(0);
    drain("p5b");

    // 6: reset while repeating, then fresh press after reset release
    btn[0] = 1'b1;
    press_windows(0, cyc);
    wait_press(0, "p6a", p);
    expect_ev(0, K_FIRE, p + DLY, p + DLY);
    wait_until(p + DLY + 4);
    check("p6_pre_reset_pending", exp_q.size(), 0);
    rst_n = 1'b0;
    #1;
    check("p6_reset_immediate", outs(), 0);
    repeat (3) @(negedge clk);
    check("p6_reset_held", outs(), 0);
    rst_n = 1'b1;
    rel   = cyc;
    press_windows(0, rel);
    @(negedge clk);
    check("p6_first_cycle", outs(), 0);
    wait_press(0, "p6b", p);
    check("p6_level", int'(level_o), 1);
    release_btn(0);
    drain("p6");

    check("final_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
